// File: rtl/booth_seq_mult.sv
// Radix-2 Booth sequential multiplier: one add/sub plus arithmetic shift per clock,
// WIDTH+1 steps on (WIDTH+1)-bit extended operands, valid/ready on both sides.
module booth_seq_mult #(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   m,
   input  logic [WIDTH-1:0]   q,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out
);

   localparam int unsigned CntW = $clog2(WIDTH + 2);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e             r_state;
   logic [WIDTH:0]     r_m;
   logic [WIDTH:0]     r_acc;
   logic [WIDTH:0]     r_q;
   logic               r_qm1;
   logic [CntW-1:0]    r_cnt;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [2*WIDTH-1:0] r_out;

   logic [WIDTH:0]     w_m_ext;
   logic [WIDTH:0]     w_q_ext;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH+1:0] w_shift;
   logic               w_last;

   always_comb begin
      w_m_ext = {signed_mode & m[WIDTH-1], m};
      w_q_ext = {signed_mode & q[WIDTH-1], q};
      case ({r_q[0], r_qm1})
         2'b01:   w_sum = r_acc + r_m;
         2'b10:   w_sum = r_acc - r_m;
         default: w_sum = r_acc;
      endcase
      // {acc, Q} after the arithmetic right shift; Q(-1) takes the old Q0
      w_shift = {w_sum[WIDTH], w_sum, r_q[WIDTH:1]};
      w_last  = (r_cnt == CntW'(1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= StIdle;
         r_m         <= '0;
         r_acc       <= '0;
         r_q         <= '0;
         r_qm1       <= 1'b0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out       <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (in_valid && r_in_ready) begin
                  r_m        <= w_m_ext;
                  r_q        <= w_q_ext;
                  r_acc      <= '0;
                  r_qm1      <= 1'b0;
                  r_cnt      <= CntW'(WIDTH + 1);
                  r_in_ready <= 1'b0;
                  r_state    <= StBusy;
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            StBusy: begin
               r_acc <= w_shift[2*WIDTH+1:WIDTH+1];
               r_q   <= w_shift[WIDTH:0];
               r_qm1 <= r_q[0];
               r_cnt <= r_cnt - 1'b1;
               // Final step: publish the product on the same edge that enters DONE
               if (w_last) begin
                  r_out       <= w_shift[2*WIDTH-1:0];
                  r_out_valid <= 1'b1;
                  r_state     <= StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out       = r_out;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Bench for booth_seq_mult at WIDTH 4, 8 and 16: directed table, hold/backpressure,
// busy-time noise, mid-operation reset and a randomised corner-weighted sweep.
module tb_booth_seq_mult;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [2:0]  in_valid_v;
   logic [2:0]  mode_v;
   logic [2:0]  out_ready_v;
   wire  [2:0]  in_ready_v;
   wire  [2:0]  out_valid_v;
   logic [3:0]  m4, q4;
   logic [7:0]  m8, q8;
   logic [15:0] m16, q16;
   wire  [7:0]  out4;
   wire  [15:0] out8;
   wire  [31:0] out16;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int          k;
      logic [63:0] exp;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      int          k;
      logic [31:0] a;
      logic [31:0] b;
      bit          s;
      logic [63:0] exp;
      int          hold;
   } vec_t;

   booth_seq_mult #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .m(m4), .q(q4), .signed_mode(mode_v[0]), .out_valid(out_valid_v[0]),
      .out_ready(out_ready_v[0]), .out(out4)
   );
   booth_seq_mult #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .m(m8), .q(q8), .signed_mode(mode_v[1]), .out_valid(out_valid_v[1]),
      .out_ready(out_ready_v[1]), .out(out8)
   );
   booth_seq_mult #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
      .m(m16), .q(q16), .signed_mode(mode_v[2]), .out_valid(out_valid_v[2]),
      .out_ready(out_ready_v[2]), .out(out16)
   );

   function automatic int wid(int k);
      return (k == 0) ? 4 : (k == 1) ? 8 : 16;
   endfunction

   function automatic logic [63:0] get_out(int k);
      case (k)
         0:       return 64'(out4);
         1:       return 64'(out8);
         default: return 64'(out16);
      endcase
   endfunction

   task automatic set_ops(int k, logic [31:0] a, logic [31:0] b);
      case (k)
         0:       begin m4 = a[3:0];   q4 = b[3:0];   end
         1:       begin m8 = a[7:0];   q8 = b[7:0];   end
         default: begin m16 = a[15:0]; q16 = b[15:0]; end
      endcase
   endtask

   function automatic logic [63:0] ref_prod(int k, logic [31:0] a, logic [31:0] b, bit s);
      int     w = wid(k);
      longint lim, sa, sb, p;
      lim = longint'(1) << w;
      sa  = longint'(a) & (lim - 1);
      sb  = longint'(b) & (lim - 1);
      if (s && sa >= lim / 2) sa = sa - lim;
      if (s && sb >= lim / 2) sb = sb - lim;
      p = sa * sb;
      return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
   endfunction

   function automatic logic [31:0] pick(int k);
      logic [31:0] lim = 32'd1 << wid(k);
      case ($urandom_range(5, 0))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return lim - 1;
         3:       return lim / 2 - 1;
         4:       return lim / 2;
         default: return $urandom & (lim - 1);
      endcase
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One full transaction on instance k, with input noise while busy and optional backpressure.
   task automatic do_op(int k, logic [31:0] a, logic [31:0] b, bit s, logic [63:0] exp,
                        int hold);
      int  n;
      bit  seen;
      sb_t e;
      @(negedge clk);
      in_valid_v[k]  = 1'b1;
      mode_v[k]      = s;
      out_ready_v[k] = 1'b0;
      set_ops(k, a, b);
      n = 0;
      while (!in_ready_v[k] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         check("accept_timeout", 64'(n), 64'd0);
         in_valid_v[k] = 1'b0;
         return;
      end
      @(posedge clk);
      e.k   = k;
      e.exp = exp;
      sb_q.push_back(e);
      #1;
      in_valid_v[k] = 1'b0;
      mode_v[k]     = ~s;
      set_ops(k, ~a, ~b);
      seen = 1'b0;
      for (n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         if (out_valid_v[k]) begin
            seen = 1'b1;
            break;
         end
         in_valid_v[k]  = 1'($urandom_range(1, 0));
         out_ready_v[k] = 1'($urandom_range(1, 0));
         mode_v[k]      = 1'($urandom_range(1, 0));
         set_ops(k, $urandom, $urandom);
      end
      in_valid_v[k]  = 1'b0;
      out_ready_v[k] = 1'b0;
      if (!seen) begin
         check("done_timeout", 64'd0, 64'd1);
         void'(sb_q.pop_front());
         return;
      end
      check("latency", 64'(n), 64'(wid(k) + 1));
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 64'd0, 64'd1);
         return;
      end
      e = sb_q.pop_front();
      check("product", get_out(k), e.exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check("hold_out", get_out(k), e.exp);
         check("hold_flags", 64'({out_valid_v[k], in_ready_v[k]}), 64'b10);
      end
      out_ready_v[k] = 1'b1;
      @(posedge clk);
      #1;
      out_ready_v[k] = 1'b0;
      check("handshake_flags", 64'({out_valid_v[k], in_ready_v[k]}), 64'b01);
      check("retain_out", get_out(k), e.exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t vecs[10];
      int   spurious;
      vecs[0] = '{2, 32'h0003, 32'hFFFB, 1'b1, 64'hFFFF_FFF1, 10};
      vecs[1] = '{2, 32'h8000, 32'h8000, 1'b1, 64'h4000_0000, 1};
      vecs[2] = '{2, 32'hFFFF, 32'hFFFF, 1'b0, 64'hFFFE_0001, 1};
      vecs[3] = '{2, 32'h7FFF, 32'h8000, 1'b1, 64'hC000_8000, 1};
      vecs[4] = '{2, 32'hFFFF, 32'hFFFF, 1'b1, 64'h0000_0001, 1};
      vecs[5] = '{2, 32'h0000, 32'h1234, 1'b1, 64'h0000_0000, 1};
      vecs[6] = '{0, 32'h8,    32'h8,    1'b1, 64'h40,        1};
      vecs[7] = '{0, 32'hF,    32'hF,    1'b0, 64'hE1,        1};
      vecs[8] = '{1, 32'h80,   32'h7F,   1'b1, 64'hC080,      1};
      vecs[9] = '{1, 32'hFF,   32'h02,   1'b0, 64'h01FE,      2};

      rst = 1'b0;
      in_valid_v = '0;
      mode_v = '0;
      out_ready_v = '0;
      m4 = '0; q4 = '0; m8 = '0; q8 = '0; m16 = '0; q16 = '0;
      #3;
      check("reset_flags", 64'({in_ready_v, out_valid_v}), 64'd0);
      check("reset_out16", get_out(2), 64'd0);
      in_valid_v = 3'b111;
      repeat (2) @(posedge clk);
      #1;
      check("reset_held_flags", 64'({in_ready_v, out_valid_v}), 64'd0);
      in_valid_v = '0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_release", 64'(in_ready_v), 64'b111);

      foreach (vecs[i])
         do_op(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, vecs[i].hold);

      // Reset in the middle of a busy operation
      @(negedge clk);
      in_valid_v[2] = 1'b1;
      mode_v[2] = 1'b1;
      set_ops(2, 32'h1234, 32'h5678);
      @(posedge clk);
      #1;
      in_valid_v[2] = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("abort_out", get_out(2), 64'd0);
      check("abort_flags", 64'({out_valid_v[2], in_ready_v[2]}), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_ready", 64'(in_ready_v[2]), 64'd1);
      spurious = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (out_valid_v[2]) spurious++;
      end
      check("abort_no_valid", 64'(spurious), 64'd0);
      do_op(2, 32'd7, 32'd6, 1'b0, 64'd42, 1);

      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 12; i++) begin
            logic [31:0] a, b;
            bit          s;
            a = pick(k);
            b = pick(k);
            s = 1'($urandom_range(1, 0));
            do_op(k, a, b, s, ref_prod(k, a, b, s), $urandom_range(2, 0));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be legal for any value 4..32.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous assert, active-low; SHALL act immediately when low, independent of clk.
REQ-004 Port in_valid  input  1  operand pair and mode are presented.
REQ-005 Port in_ready  output  1  block can accept an operand pair.
REQ-006 Port m  input  WIDTH  multiplicand.
REQ-007 Port q  input  WIDTH  multiplier.
REQ-008 Port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned operands.
REQ-009 Port out_valid  output  1  product is valid.
REQ-010 Port out_ready  input  1  consumer accepts the product.
REQ-011 Port out  output  2*WIDTH  product, registered.

Function
REQ-012 The block SHALL be a radix-2 Booth sequential multiplier with one add/sub-and-arithmetic-shift step per clock.
REQ-013 FSM states SHALL be IDLE, BUSY and DONE: IDLE->BUSY on in_valid&&in_ready; BUSY->DONE when the step counter expires; DONE->IDLE on out_valid&&out_ready.
REQ-014 in_ready SHALL be 1 only in IDLE; in_valid in BUSY or DONE SHALL be ignored.
REQ-015 On acceptance, m, q and signed_mode SHALL be captured, each extended to WIDTH+1 bits (sign-extended if signed_mode=1, zero-extended if 0); later input changes SHALL NOT affect the result.
REQ-016 Accumulator SHALL be WIDTH+1 bits, cleared on acceptance; the appended Q(-1) bit SHALL be cleared on acceptance.
REQ-017 Each BUSY step: pair {Q0,Q-1}=01 adds the extended m; 10 subtracts it; 00/11 no add; then {acc,Q,Q-1} arithmetic-shifts right by one.
REQ-018 Exactly WIDTH+1 steps SHALL be performed; the counter SHALL be ceil(log2(WIDTH+2)) bits wide.
REQ-019 out_valid SHALL rise on the (WIDTH+1)th rising edge after the acceptance edge (17 cycles for WIDTH=16).
REQ-020 out SHALL equal the low 2*WIDTH bits of the 2*(WIDTH+1)-bit Booth result, i.e. the exact signed or unsigned product.
REQ-021 out SHALL be loaded once on entry to DONE and held stable while out_valid=1 and out_ready=0.
REQ-022 out SHALL retain the last product after DONE->IDLE until the next product is loaded.
REQ-023 out_ready asserted outside DONE SHALL have no effect.
REQ-024 When out_valid&&out_ready, the block SHALL return to IDLE and assert in_ready on the next cycle; no accept/complete overlap.
REQ-025 The most-negative signed operand SHALL multiply correctly (no overflow), since the extended width covers -2^(WIDTH-1).

Reset
REQ-026 While rst=0, state SHALL be IDLE, and the accumulator, Q, Q-1, counter and out SHALL be 0.
REQ-027 While rst=0, in_ready SHALL be 0 and out_valid SHALL be 0; in_ready SHALL be 1 on the first cycle after release.
REQ-028 Reset asserted in BUSY or DONE SHALL abort the operation; no out_valid pulse for it SHALL follow release.

Verification
REQ-029 WIDTH=16, signed_mode=1, m=0x0003, q=0xFFFB -> out_valid 17 cycles after accept, out=0xFFFFFFF1 (-15).
REQ-030 WIDTH=16, signed, m=q=0x8000 -> out=0x40000000; unsigned, m=q=0xFFFF -> out=0xFFFE0001.
REQ-031 out_ready held 0 for 10 cycles in DONE -> out and out_valid stable, in_ready 0; then out_ready=1 -> IDLE and in_ready=1 next cycle.
REQ-032 in_valid pulses with new m/q during BUSY -> ignored; the result reflects the captured operands only.
REQ-033 rst low at step 8 of 17 -> out=0, out_valid=0 immediately; after release, new op m=7,q=6 unsigned -> out=42.
REQ-034 Randomised sweep at WIDTH=4, 8 and 16, both modes, including 0, 1, -1, max and min operands, vs reference product -> all match with exact latency WIDTH+1.
